// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write arbiter: state encoding, clog2 helper, parameter defaults.
// Purely declarative; no logic, latency or backpressure of its own.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF   = 4;
  localparam int WORD_SIZE_DEF = 32;
  localparam int MAX_BURST_DEF = 8;

  // Returns at least 1 so single-entry indices still get a real bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Circular find-first: lowest-offset set bit of req starting at ptr; idx falls back to ptr.
// Purely combinational, zero latency; no backpressure.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk offsets high to low so the closest requester to ptr is written last and wins.
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with locked bursts onto one FIFO write port; zero-cycle latency, fifo_full stalls all.
// Optional statistics counters under FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           fifo_full,
  output logic                           fifo_wr_en,
  output logic [WORD_SIZE-1:0]           fifo_data_in,
  output logic [clog2(NUM_REQ)-1:0]      grant_id,
  output logic                           busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                           stat_clr,
  output logic [NUM_REQ*CNT_W-1:0]       stat_grants,
  output logic [CNT_W-1:0]               stat_stall
`endif
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int BC_W  = clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [IDX_W-1:0] sel;
  logic             xfer;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  always_comb begin
    sel  = (state_q == ARB_LOCK) ? owner_q : pick_idx;
    xfer = rst && !fifo_full &&
           ((state_q == ARB_LOCK) ? req_valid[owner_q] : pick_found);
    req_ready = '0;
    if (rst && !fifo_full) req_ready[sel] = 1'b1;
    fifo_wr_en   = xfer;
    grant_id     = rst ? sel : '0;
    fifo_data_in = rst ? req_data[sel*WORD_SIZE +: WORD_SIZE] : '0;
    busy         = rst && (state_q == ARB_LOCK);
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    if (xfer) begin
      if (state_q == ARB_IDLE) begin
        if (req_last[sel] || MAX_BURST == 1) begin
          rr_ptr_d = next_idx(sel);
        end else begin
          state_d    = ARB_LOCK;
          owner_d    = sel;
          beat_cnt_d = BC_W'(1);
        end
      end else begin
        // Beat count of the word being accepted now is beat_cnt_q + 1.
        if (req_last[owner_q] || beat_cnt_q == BC_W'(MAX_BURST - 1)) begin
          state_d    = ARB_IDLE;
          rr_ptr_d   = next_idx(owner_q);
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + BC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ*CNT_W-1:0] stat_grants_q, stat_grants_d;
  logic [CNT_W-1:0]         stat_stall_q, stat_stall_d;

  always_comb begin
    stat_grants_d = stat_grants_q;
    stat_stall_d  = stat_stall_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer && sel == IDX_W'(i) && stat_grants_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})
        stat_grants_d[i*CNT_W +: CNT_W] = stat_grants_q[i*CNT_W +: CNT_W] + CNT_W'(1);
    end
    if ((|req_valid) && fifo_full && stat_stall_q != {CNT_W{1'b1}})
      stat_stall_d = stat_stall_q + CNT_W'(1);
    if (stat_clr) begin
      stat_grants_d = '0;
      stat_stall_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_grants_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_grants = stat_grants_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=8); inputs change 1 after posedge, outputs sampled 2 after.
module tb_fifo_wr_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_last;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         fifo_full;
  logic         fifo_wr_en;
  logic [31:0]  fifo_data_in;
  logic [1:0]   grant_id;
  logic         busy;
`ifdef FIFO_ARB_STATS_EN
  logic         stat_clr;
  logic [63:0]  stat_grants;
  logic [15:0]  stat_stall;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .WORD_SIZE (32),
    .MAX_BURST (8),
    .CNT_W     (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_grants  (stat_grants),
    .stat_stall   (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the combinational outputs for the current inputs, then advance one clock.
  task automatic cyc(input string tag, input logic exp_wr, input logic [1:0] exp_gnt,
                     input logic [31:0] exp_dat, input logic exp_busy, input logic [3:0] exp_rdy);
    #1;
    chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(exp_wr));
    chk({tag, ".grant"}, 32'(grant_id),   32'(exp_gnt));
    chk({tag, ".data"},  fifo_data_in,    exp_dat);
    chk({tag, ".busy"},  32'(busy),       32'(exp_busy));
    chk({tag, ".ready"}, 32'(req_ready),  32'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
    fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif

    // Reset holds every output low even with all requesters valid.
    cyc("rst0", 1'b0, 2'd0, 32'h0, 1'b0, 4'b0000);
    cyc("rst1", 1'b0, 2'd0, 32'h0, 1'b0, 4'b0000);

    // Round robin, single-beat words: A0 A1 A2 A3 A0.
    rst = 1'b1;
    for (int i = 0; i < 5; i++)
      cyc($sformatf("rr%0d", i), 1'b1, 2'(i % 4), 32'h0000_00A0 + 32'(i % 4), 1'b0,
          4'(1 << (i % 4)));

    // Burst lock: req1 three beats while req2 waits; rr_ptr is 1 here.
    req_valid = 4'b0110;
    req_last  = 4'b0100;
    cyc("lk1", 1'b1, 2'd1, 32'h0000_00A1, 1'b0, 4'b0010);
    cyc("lk2", 1'b1, 2'd1, 32'h0000_00A1, 1'b1, 4'b0010);
    req_last  = 4'b0110;
    cyc("lk3", 1'b1, 2'd1, 32'h0000_00A1, 1'b1, 4'b0010);
    req_valid = 4'b0100;
    cyc("lk4", 1'b1, 2'd2, 32'h0000_00A2, 1'b0, 4'b0100);

    // Burst cap: req0 never signals last; released after 8 beats, req3 slips in once.
    req_valid = 4'b0001;
    req_last  = 4'b1000;
    cyc("cap1", 1'b1, 2'd0, 32'h0000_00A0, 1'b0, 4'b0001);
    req_valid = 4'b1001;
    for (int b = 2; b <= 8; b++)
      cyc($sformatf("cap%0d", b), 1'b1, 2'd0, 32'h0000_00A0, 1'b1, 4'b0001);
    cyc("cap_r3", 1'b1, 2'd3, 32'h0000_00A3, 1'b0, 4'b1000);
    cyc("cap9",   1'b1, 2'd0, 32'h0000_00A0, 1'b0, 4'b0001);
    cyc("cap10",  1'b1, 2'd0, 32'h0000_00A0, 1'b1, 4'b0001);
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    cyc("cap_end", 1'b1, 2'd0, 32'h0000_00A0, 1'b1, 4'b0001);

    // Idle with nobody valid: grant_id shows rr_ptr (1) and its ready bit is up.
    req_valid = 4'b0000;
    req_last  = 4'b0000;
`ifdef FIFO_ARB_STATS_EN
    stat_clr  = 1'b1;
`endif
    cyc("idle1", 1'b0, 2'd1, 32'h0000_00A1, 1'b0, 4'b0010);
`ifdef FIFO_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif

    // Full stall during beat 4 of a req2 burst; the cap must still land on beat 8.
    req_valid = 4'b0100;
    cyc("fs1", 1'b1, 2'd2, 32'h0000_00A2, 1'b0, 4'b0100);
    req_valid = 4'b0101;
    cyc("fs2", 1'b1, 2'd2, 32'h0000_00A2, 1'b1, 4'b0100);
    cyc("fs3", 1'b1, 2'd2, 32'h0000_00A2, 1'b1, 4'b0100);
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++)
      cyc($sformatf("stall%0d", s), 1'b0, 2'd2, 32'h0000_00A2, 1'b1, 4'b0000);
    fifo_full = 1'b0;
    for (int b = 4; b <= 8; b++)
      cyc($sformatf("fs%0d", b), 1'b1, 2'd2, 32'h0000_00A2, 1'b1, 4'b0100);
    req_last  = 4'b0001;
    cyc("fs_next", 1'b1, 2'd0, 32'h0000_00A0, 1'b0, 4'b0001);
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    cyc("idle2", 1'b0, 2'd1, 32'h0000_00A1, 1'b0, 4'b0010);
`ifdef FIFO_ARB_STATS_EN
    chk("stat_stall",   32'(stat_stall),         32'd3);
    chk("stat_grants2", 32'(stat_grants[47:32]), 32'd8);
    chk("stat_grants0", 32'(stat_grants[15:0]),  32'd1);
`endif

    // Reset in the middle of a req3 lock; afterwards req0 wins over req3.
    req_valid = 4'b1000;
    cyc("rm1", 1'b1, 2'd3, 32'h0000_00A3, 1'b0, 4'b1000);
    cyc("rm2", 1'b1, 2'd3, 32'h0000_00A3, 1'b1, 4'b1000);
    rst = 1'b0;
    cyc("rm_rst", 1'b0, 2'd0, 32'h0, 1'b0, 4'b0000);
    rst = 1'b1;
    req_valid = 4'b1001;
    req_last  = 4'b1001;
    cyc("rm_after", 1'b1, 2'd0, 32'h0000_00A0, 1'b0, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
